// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer:
// register offsets, CTRL bit positions and the run-state encoding.
package mmio_timer_pkg;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_LOAD     = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_STATUS   = 3'd3;
    localparam logic [2:0] OFF_PRESCALE = 3'd4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IRQ  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/mmio_timer_tick.sv
// Prescaler: counts while enabled and pulses tick when the count equals div,
// wrapping to 0 on that cycle. A larger count wraps through 16'hFFFF first.
module tick_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign tick = en && (cnt_q == div);

    // Next prescale count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 16'd0;
        end else if (en) begin
            cnt_d = (cnt_q == div) ? 16'd0 : cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescale counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with prescaler, one-shot or auto-reload
// operation and a level interrupt. Run state is visible only as CTRL.EN.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        Irq
);

    state_e      state_q, state_d;
    logic        auto_q, auto_d;
    logic        irq_en_q, irq_en_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        expired_q, expired_d;
    logic [15:0] prescale_q, prescale_d;

    logic [2:0] off_s;
    logic       wr_s, wr_ctrl_s, wr_load_s, wr_count_s, wr_status_s, wr_pre_s;
    logic       run_s, tick_s, expire_s, run_entry_s, halt_restart_s;
    logic       unused_s;

    assign Hit         = (DataAdr[31:5] == BASE_ADDR[31:5]);
    assign off_s       = DataAdr[4:2];
    assign unused_s    = ^DataAdr[1:0];
    assign wr_s        = MemWrite && Hit;
    assign wr_ctrl_s   = wr_s && (off_s == OFF_CTRL);
    assign wr_load_s   = wr_s && (off_s == OFF_LOAD);
    assign wr_count_s  = wr_s && (off_s == OFF_COUNT);
    assign wr_status_s = wr_s && (off_s == OFF_STATUS);
    assign wr_pre_s    = wr_s && (off_s == OFF_PRESCALE);

    assign run_s          = (state_q == ST_RUN);
    assign run_entry_s    = wr_ctrl_s && WriteData[CTRL_EN] && !run_s;
    assign halt_restart_s = wr_ctrl_s && WriteData[CTRL_EN] && (state_q == ST_HALT);
    assign expire_s       = run_s && tick_s && (count_q == 32'd0);

    tick_gen u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (run_entry_s),
        .en    (run_s),
        .div   (prescale_q),
        .tick  (tick_s)
    );

    // Next-state for the FSM and all programmer-visible registers.
    always_comb begin
        if (wr_ctrl_s && WriteData[CTRL_EN]) begin
            state_d = ST_RUN;
        end else if (wr_ctrl_s && run_s) begin
            state_d = ST_IDLE;
        end else if (expire_s && !auto_q) begin
            state_d = ST_HALT;
        end else begin
            state_d = state_q;
        end

        auto_d   = wr_ctrl_s ? WriteData[CTRL_AUTO] : auto_q;
        irq_en_d = wr_ctrl_s ? WriteData[CTRL_IRQ] : irq_en_q;
        load_d   = wr_load_s ? WriteData : load_q;
        prescale_d = wr_pre_s ? WriteData[15:0] : prescale_q;

        // A software COUNT write beats any same-cycle decrement or reload.
        if (wr_count_s) begin
            count_d = WriteData;
        end else if (halt_restart_s) begin
            count_d = load_q;
        end else if (run_s && tick_s) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (auto_q) begin
                count_d = load_q;
            end else begin
                count_d = 32'd0;
            end
        end else begin
            count_d = count_q;
        end

        if (expire_s) begin
            expired_d = 1'b1;
        end else if (wr_status_s && WriteData[0]) begin
            expired_d = 1'b0;
        end else begin
            expired_d = expired_q;
        end
    end

    // Register state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            load_q     <= 32'd0;
            count_q    <= 32'd0;
            expired_q  <= 1'b0;
            prescale_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            load_q     <= load_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
            prescale_q <= prescale_d;
        end
    end

    // Side-effect-free read mux.
    always_comb begin
        ReadData = 32'd0;
        if (Hit) begin
            case (off_s)
                OFF_CTRL:     ReadData = {29'd0, irq_en_q, auto_q, run_s};
                OFF_LOAD:     ReadData = load_q;
                OFF_COUNT:    ReadData = count_q;
                OFF_STATUS:   ReadData = {31'd0, expired_q};
                OFF_PRESCALE: ReadData = {16'd0, prescale_q};
                default:      ReadData = 32'd0;
            endcase
        end else begin
            ReadData = 32'd0;
        end
    end

    assign Irq = expired_q && irq_en_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: a decode/register vector table followed by
// hand-timed sequences for one-shot, auto-reload, collisions and reset.
module tb_mmio_timer;
    import mmio_timer_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;
    logic        Irq;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_hit;
    } vec_t;

    vec_t        vecs [24];
    logic [31:0] auto_seq [7];

    mmio_timer #(.BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .Irq       (Irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [2:0] off, output logic [31:0] v);
        MemWrite = 1'b0;
        DataAdr  = BASE + {27'd0, off, 2'b00};
        #1;
        v = ReadData;
    endtask

    task automatic chk_reg(input string name, input logic [2:0] off, input logic [31:0] exp);
        logic [31:0] v;
        rd(off, v);
        chk(name, v, exp);
    endtask

    task automatic chk_irq(input string name, input logic exp);
        chk(name, {31'd0, Irq}, {31'd0, exp});
    endtask

    // Called in the low clock phase; commits on the following rising edge.
    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        DataAdr   = BASE + {27'd0, off, 2'b00};
        WriteData = d;
        MemWrite  = 1'b1;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        MemWrite = 1'b0;
        reset    = 1'b0;
        cycles(2);
        reset    = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0,         1'b1};
        vecs[1]  = '{1'b0, 32'h0000_1004, 32'h0,         32'h0,         1'b1};
        vecs[2]  = '{1'b0, 32'h0000_1008, 32'h0,         32'h0,         1'b1};
        vecs[3]  = '{1'b0, 32'h0000_100C, 32'h0,         32'h0,         1'b1};
        vecs[4]  = '{1'b0, 32'h0000_1010, 32'h0,         32'h0,         1'b1};
        vecs[5]  = '{1'b1, 32'h0000_1007, 32'hDEAD_BEEF, 32'h0,         1'b1};
        vecs[6]  = '{1'b0, 32'h0000_1005, 32'h0,         32'hDEAD_BEEF, 1'b1};
        vecs[7]  = '{1'b1, 32'h0000_1010, 32'hFFFF_1234, 32'h0,         1'b1};
        vecs[8]  = '{1'b0, 32'h0000_1010, 32'h0,         32'h0000_1234, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFF6, 32'h0,         1'b1};
        vecs[10] = '{1'b0, 32'h0000_1000, 32'h0,         32'h0000_0006, 1'b1};
        vecs[11] = '{1'b1, 32'h0000_1008, 32'h0000_0007, 32'h0,         1'b1};
        vecs[12] = '{1'b0, 32'h0000_1008, 32'h0,         32'h0000_0007, 1'b1};
        vecs[13] = '{1'b1, 32'h0000_101C, 32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[14] = '{1'b1, 32'h0000_1020, 32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[15] = '{1'b0, 32'h0000_101C, 32'h0,         32'h0,         1'b1};
        vecs[16] = '{1'b0, 32'h0000_1020, 32'h0,         32'h0,         1'b0};
        vecs[17] = '{1'b0, 32'h0000_1000, 32'h0,         32'h0000_0006, 1'b1};
        vecs[18] = '{1'b0, 32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 1'b1};
        vecs[19] = '{1'b0, 32'h0000_1008, 32'h0,         32'h0000_0007, 1'b1};
        vecs[20] = '{1'b0, 32'h0000_1010, 32'h0,         32'h0000_1234, 1'b1};
        vecs[21] = '{1'b0, 32'h0000_100C, 32'h0,         32'h0,         1'b1};
        vecs[22] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'h0,         1'b0};
        vecs[23] = '{1'b0, 32'h0000_1018, 32'h0,         32'h0,         1'b1};
        auto_seq = '{32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd2};

        reset = 1'b0; MemWrite = 1'b0; DataAdr = 32'd0; WriteData = 32'd0;
        #2;
        chk_irq("rst_irq", 1'b0);
        chk_reg("rst_ctrl", OFF_CTRL, 32'd0);
        chk_reg("rst_count", OFF_COUNT, 32'd0);
        cycles(2);
        reset = 1'b1;

        // Register access and address decode with the timer idle.
        for (int i = 0; i < 24; i++) begin
            DataAdr   = vecs[i].adr;
            WriteData = vecs[i].wdata;
            MemWrite  = vecs[i].wr;
            #1;
            chk($sformatf("vec%0d_hit", i), {31'd0, Hit}, {31'd0, vecs[i].exp_hit});
            if (!vecs[i].wr) chk($sformatf("vec%0d_rd", i), ReadData, vecs[i].exp_rd);
            chk_irq($sformatf("vec%0d_irq", i), 1'b0);
            @(negedge clk);
            MemWrite = 1'b0;
        end

        // One-shot expiry, then restart from HALT and COUNT-write override.
        do_reset();
        wr(OFF_PRESCALE, 32'd0);
        wr(OFF_LOAD, 32'd3);
        wr(OFF_COUNT, 32'd3);
        wr(OFF_CTRL, 32'd5);
        chk_reg("os_run_ctrl", OFF_CTRL, 32'd5);
        cycles(3);
        chk_reg("os_pre_cnt", OFF_COUNT, 32'd0);
        chk_reg("os_pre_exp", OFF_STATUS, 32'd0);
        chk_irq("os_pre_irq", 1'b0);
        cycles(1);
        chk_reg("os_exp", OFF_STATUS, 32'd1);
        chk_irq("os_irq", 1'b1);
        chk_reg("os_cnt", OFF_COUNT, 32'd0);
        chk_reg("os_ctrl", OFF_CTRL, 32'd4);
        cycles(1);
        chk_reg("os_halt_ctrl", OFF_CTRL, 32'd4);
        wr(OFF_CTRL, 32'd5);
        chk_reg("halt_restart_cnt", OFF_COUNT, 32'd3);
        chk_reg("halt_restart_ctrl", OFF_CTRL, 32'd5);
        wr(OFF_COUNT, 32'd10);
        chk_reg("cnt_override", OFF_COUNT, 32'd10);
        wr(OFF_CTRL, 32'd4);
        chk_reg("stop_cnt", OFF_COUNT, 32'd9);
        chk_reg("stop_ctrl", OFF_CTRL, 32'd4);
        cycles(2);
        chk_reg("idle_hold_cnt", OFF_COUNT, 32'd9);
        wr(OFF_STATUS, 32'd1);
        chk_reg("clr_exp", OFF_STATUS, 32'd0);
        chk_irq("clr_irq", 1'b0);

        // Auto-reload with prescale 2: COUNT steps every other cycle.
        do_reset();
        wr(OFF_LOAD, 32'd2);
        wr(OFF_PRESCALE, 32'd1);
        wr(OFF_COUNT, 32'd2);
        wr(OFF_CTRL, 32'd3);
        chk_reg("auto_cnt0", OFF_COUNT, auto_seq[0]);
        for (int k = 1; k < 7; k++) begin
            @(negedge clk);
            chk_reg($sformatf("auto_cnt%0d", k), OFF_COUNT, auto_seq[k]);
            chk_reg($sformatf("auto_exp%0d", k), OFF_STATUS, (k == 6) ? 32'd1 : 32'd0);
        end
        chk_reg("auto_ctrl", OFF_CTRL, 32'd3);
        wr(OFF_STATUS, 32'd1);
        chk_reg("auto_clr", OFF_STATUS, 32'd0);
        chk_reg("auto_cnt7", OFF_COUNT, 32'd2);
        cycles(4);
        chk_reg("auto_exp11", OFF_STATUS, 32'd0);
        cycles(1);
        chk_reg("auto_exp12", OFF_STATUS, 32'd1);
        chk_reg("auto_cnt12", OFF_COUNT, 32'd2);

        // Clear colliding with expiry, then clear one cycle later.
        do_reset();
        wr(OFF_LOAD, 32'd2);
        wr(OFF_PRESCALE, 32'd1);
        wr(OFF_COUNT, 32'd2);
        wr(OFF_CTRL, 32'd7);
        cycles(5);
        wr(OFF_STATUS, 32'd1);
        chk_reg("coll_exp", OFF_STATUS, 32'd1);
        chk_irq("coll_irq", 1'b1);
        wr(OFF_STATUS, 32'd1);
        chk_reg("late_clr_exp", OFF_STATUS, 32'd0);
        chk_irq("late_clr_irq", 1'b0);

        // PRESCALE lowered mid-run keeps the prescale count.
        do_reset();
        wr(OFF_PRESCALE, 32'd5);
        wr(OFF_LOAD, 32'd100);
        wr(OFF_COUNT, 32'd100);
        wr(OFF_CTRL, 32'd1);
        cycles(1);
        wr(OFF_PRESCALE, 32'd2);
        chk_reg("pre_chg_cnt", OFF_COUNT, 32'd100);
        cycles(1);
        chk_reg("pre_chg_tick", OFF_COUNT, 32'd99);

        // Asynchronous reset in the middle of a run.
        do_reset();
        wr(OFF_LOAD, 32'd9);
        wr(OFF_COUNT, 32'd9);
        wr(OFF_CTRL, 32'd5);
        cycles(4);
        chk_reg("mid_cnt", OFF_COUNT, 32'd5);
        reset = 1'b0;
        #1;
        chk_irq("arst_irq", 1'b0);
        chk_reg("arst_ctrl", OFF_CTRL, 32'd0);
        chk_reg("arst_load", OFF_LOAD, 32'd0);
        chk_reg("arst_count", OFF_COUNT, 32'd0);
        chk_reg("arst_status", OFF_STATUS, 32'd0);
        chk_reg("arst_pre", OFF_PRESCALE, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cycles(2);
        chk_reg("post_rst_ctrl", OFF_CTRL, 32'd0);
        chk_reg("post_rst_cnt", OFF_COUNT, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000, word-aligned base of a 32-byte register window.
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port MemWrite  input  1  processor write strobe, one cycle per store.
REQ-005 SHALL have port DataAdr  input  32  processor byte address.
REQ-006 SHALL have port WriteData  input  32  processor store data.
REQ-007 SHALL have port ReadData  output  32  register read data for the processor load path.
REQ-008 SHALL have port Hit  output  1  high when DataAdr[31:5] == BASE_ADDR[31:5].
REQ-009 SHALL have port Irq  output  1  level interrupt request.

Function
REQ-010 SHALL decode offset DataAdr[4:2] and ignore DataAdr[1:0]: 0 CTRL, 1 LOAD, 2 COUNT, 3 STATUS, 4 PRESCALE, 5-7 unmapped.
REQ-011 SHALL fix field layouts as follows: CTRL bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, other bits read 0; LOAD 32 bits; COUNT 32 bits; STATUS bit0 EXPIRED; PRESCALE bits[15:0], bits[31:16] read 0.
REQ-012 SHALL commit a write at the rising edge on which MemWrite=1 and Hit=1; writes with Hit=0, and writes to unmapped offsets, SHALL change no state.
REQ-013 SHALL drive ReadData combinationally from the addressed register's current value when Hit=1, and 0 when Hit=0 or the offset is unmapped; reads SHALL have no side effects.
REQ-014 SHALL implement FSM states IDLE, RUN, HALT; the state SHALL be readable only through CTRL.EN (1 in RUN).
REQ-015 SHALL use a 16-bit prescale counter, active only in RUN, that asserts a tick and wraps to 0 when it equals PRESCALE; PRESCALE=0 SHALL tick every cycle.
REQ-016 SHALL update COUNT on each RUN tick: if COUNT != 0, COUNT decrements by 1; if COUNT == 0, an expire event occurs.
REQ-017 SHALL make the expire period (LOAD+1)*(PRESCALE+1) cycles from RUN entry when COUNT starts equal to LOAD.
REQ-018 SHALL, on expire, set STATUS.EXPIRED; with AUTO_RELOAD=1 it SHALL load COUNT=LOAD and stay in RUN; with AUTO_RELOAD=0 it SHALL keep COUNT=0, clear EN, and enter HALT.
REQ-019 SHALL apply the following transitions: IDLE->RUN on a CTRL write with EN=1 (COUNT unchanged); HALT->RUN on a CTRL write with EN=1 (COUNT<=LOAD); RUN->IDLE on a CTRL write with EN=0 (COUNT held); each RUN entry SHALL clear the prescale counter.
REQ-020 SHALL, on a COUNT write, override a same-cycle decrement or reload with the written value; an expire event in that cycle SHALL still set EXPIRED.
REQ-021 SHALL clear EXPIRED when STATUS is written with bit0=1; a same-cycle expire event SHALL win and leave EXPIRED=1.
REQ-022 SHALL, on a PRESCALE write in RUN, take effect in the next comparison without resetting the prescale counter; if the counter already exceeds the new value, it SHALL wrap through 16'hFFFF to 0 before the next tick.
REQ-023 SHALL drive Irq = STATUS.EXPIRED & CTRL.IRQ_EN combinationally from registers.

Reset
REQ-024 SHALL, while reset=0, immediately force: state IDLE; CTRL, LOAD, COUNT, STATUS, PRESCALE and the prescale counter to 0; Irq=0.
REQ-025 SHALL abort an in-progress count when reset is asserted mid-RUN, with no expire event; operation SHALL resume on the first rising edge after reset returns to 1.

Structure
REQ-026 SHALL place the register offset constants, CTRL bit indices and the state enum type in shared package mmio_timer_pkg.
REQ-027 SHALL implement the prescaler as sub-module tick_gen, with ports clk, reset, clr, en, div[15:0] and tick.

Verification
REQ-028 SHALL cover one-shot: PRESCALE=0, LOAD=3, COUNT=3, CTRL=5 -> EXPIRED and Irq rise 4 cycles after RUN entry; COUNT=0; EN reads 0.
REQ-029 SHALL cover auto-reload: LOAD=2, PRESCALE=1, CTRL=3 -> EXPIRED set every 6 cycles; COUNT sequence 2,2,1,1,0,0,2.
REQ-030 SHALL cover the clear/expire collision: a STATUS=1 write in the expire cycle -> EXPIRED stays 1; a write one cycle later -> EXPIRED=0 and Irq=0.
REQ-031 SHALL cover decode: a write to BASE_ADDR+0x1C and to BASE_ADDR+0x20 -> no register changes; read of 0x1C -> 0, Hit=1; read of 0x20 -> Hit=0, ReadData=0.
REQ-032 SHALL cover reset mid-RUN: reset=0 while COUNT=5 -> all registers read 0, Irq=0, state IDLE, with no clock edge required.
REQ-033 SHALL cover a COUNT write in RUN: write COUNT=10 while a tick is pending -> COUNT reads 10 the next cycle, not 9.
